pipe_skid_reg: RTL and testbench

PIPE_SKID_REG -- requirements
Module: pipe_skid_reg

---
 rtl/pipe_skid_reg.sv | 101 ++++++++++
 tb/tb_pipe_skid_reg.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/pipe_skid_reg.sv
// pipe_skid_reg: two-entry skid register for a valid/ready pipeline stage.
// Both handshake outputs are decoded from the registered state only, so
// there is no combinational path from out_ready or in_valid to any output.
// out_data is always the main register. The skid register holds a second
// beat that was accepted while the downstream side stalled.
module pipe_skid_reg #(
   parameter int unsigned           WIDTH     = 8,
   parameter logic [WIDTH-1:0]      RESET_VAL = '0
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in_data,
   output logic             in_ready,
   output logic             out_valid,
   output logic [WIDTH-1:0] out_data,
   input  logic             out_ready,
   output logic [1:0]       count
);

   // The state encoding equals the number of beats held, so count is the state.
   typedef enum logic [1:0] {
      S_EMPTY = 2'd0,
      S_BUSY  = 2'd1,
      S_FULL  = 2'd2
   } state_t;

   state_t           r_state;
   logic [WIDTH-1:0] r_main;
   logic [WIDTH-1:0] r_skid;

   state_t           w_state_nxt;
   logic [WIDTH-1:0] w_main_nxt;
   logic [WIDTH-1:0] w_skid_nxt;
   logic             w_in_xfer;
   logic             w_out_xfer;

   // Handshake and payload outputs, decoded from registered state only.
   assign in_ready  = (r_state != S_FULL);
   assign out_valid = (r_state != S_EMPTY);
   assign out_data  = r_main;
   assign count     = r_state;

   assign w_in_xfer  = in_valid  & in_ready;
   assign w_out_xfer = out_valid & out_ready;

   // Next-state and datapath selection for each state and transfer combination.
   always_comb begin
      // NOTE: every target gets its hold value first, so no path leaves one unassigned and no latch is inferred.
      w_state_nxt = r_state;
      w_main_nxt  = r_main;
      w_skid_nxt  = r_skid;
      unique case (r_state)
         S_EMPTY: begin
            if (w_in_xfer) begin
               w_main_nxt  = in_data;
               w_state_nxt = S_BUSY;
            end
         end
         S_BUSY: begin
            if (w_in_xfer && w_out_xfer) begin
               // The head leaves as the new beat arrives, so the new beat becomes the head.
               w_main_nxt = in_data;
            end else if (w_in_xfer) begin
               w_skid_nxt  = in_data;
               w_state_nxt = S_FULL;
            end else if (w_out_xfer) begin
               w_state_nxt = S_EMPTY;
            end
         end
         S_FULL: begin
            // in_ready is low here, so only the output side can move.
            if (w_out_xfer) begin
               w_main_nxt  = r_skid;
               w_state_nxt = S_BUSY;
            end
         end
         default: begin
            // The unused encoding recovers to an empty stage.
            w_state_nxt = S_EMPTY;
         end
      endcase
   end

   // State and data registers; reset and flush both clear the stage and override any transfer.
   always_ff @(posedge clk) begin
      // NOTE: non-blocking assignments so every register samples pre-edge values, independent of statement order.
      if (reset || flush) begin
         // The data registers are cleared too, because out_data is visible while the stage is empty.
         r_state <= S_EMPTY;
         r_main  <= RESET_VAL;
         r_skid  <= RESET_VAL;
      end else begin
         r_state <= w_state_nxt;
         r_main  <= w_main_nxt;
         r_skid  <= w_skid_nxt;
      end
   end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// tb_pipe_skid_reg: directed checks of the skid register followed by a
// randomised handshake phase scored against a queue model.
module tb_pipe_skid_reg;

   localparam int unsigned W = 8;
   localparam logic [W-1:0] RV = 8'hFF;

   logic         clk;
   logic         reset;
   logic         flush;
   logic         in_valid;
   logic [W-1:0] in_data;
   logic         in_ready;
   logic         out_valid;
   logic [W-1:0] out_data;
   logic         out_ready;
   logic [1:0]   count;

   int n_vec = 0;
   int n_err = 0;

   logic [W-1:0] q[$];
   logic         exp_in;
   logic         exp_out;

   pipe_skid_reg #(.WIDTH(W), .RESET_VAL(RV)) dut (
      .clk       (clk),
      .reset     (reset),
      .flush     (flush),
      .in_valid  (in_valid),
      .in_data   (in_data),
      .in_ready  (in_ready),
      .out_valid (out_valid),
      .out_data  (out_data),
      .out_ready (out_ready),
      .count     (count)
   );

   // Free-running clock, 10 time units per period.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Advance one rising edge and settle past it before sampling.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks the full visible state in one call.
   task automatic check_all(input string tag, input logic [1:0] e_cnt, input logic e_ov,
                            input logic e_ir, input logic [W-1:0] e_data);
      check({tag, ".count"},     64'(count),     64'(e_cnt));
      check({tag, ".out_valid"}, 64'(out_valid), 64'(e_ov));
      check({tag, ".in_ready"},  64'(in_ready),  64'(e_ir));
      check({tag, ".out_data"},  64'(out_data),  64'(e_data));
   endtask

   // Directed steps, then the randomised scoreboard phase.
   initial begin
      reset     = 1'b1;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      out_ready = 1'b0;
      tick();
      check_all("reset", 2'd0, 1'b0, 1'b1, RV);
      tick();
      reset = 1'b0;

      // Streaming with out_ready held high: one-cycle latency, depth stays 1.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h01; tick(); check_all("stream1", 2'd1, 1'b1, 1'b1, 8'h01);
      in_data   = 8'h02; tick(); check_all("stream2", 2'd1, 1'b1, 1'b1, 8'h02);
      in_data   = 8'h03; tick(); check_all("stream3", 2'd1, 1'b1, 1'b1, 8'h03);
      in_valid  = 1'b0;  tick(); check_all("stream_drain", 2'd0, 1'b0, 1'b1, 8'h03);

      // Backpressure: fill both entries, offer a third beat that must be refused.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'hA5; tick(); check_all("bp_push1", 2'd1, 1'b1, 1'b1, 8'hA5);
      in_data   = 8'h5A; tick(); check_all("bp_push2", 2'd2, 1'b1, 1'b0, 8'hA5);
      in_data   = 8'h77; tick(); check_all("bp_full_hold", 2'd2, 1'b1, 1'b0, 8'hA5);
      // Drain edge from FULL with 0x77 still offered: in_ready was low, so it is dropped.
      out_ready = 1'b1;  tick(); check_all("bp_drain1", 2'd1, 1'b1, 1'b1, 8'h5A);
      in_valid  = 1'b0;  tick(); check_all("bp_drain2", 2'd0, 1'b0, 1'b1, 8'h5A);

      // Simultaneous input and output transfer in BUSY replaces main, skid stays unused.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h10; tick(); check_all("sim_load", 2'd1, 1'b1, 1'b1, 8'h10);
      out_ready = 1'b1;
      in_data   = 8'h20; tick(); check_all("sim_xfer", 2'd1, 1'b1, 1'b1, 8'h20);
      in_valid  = 1'b0;  tick(); check_all("sim_drain", 2'd0, 1'b0, 1'b1, 8'h20);

      // BUSY hold with no transfer on either side.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h3C; tick();
      in_valid  = 1'b0;  tick(); check_all("busy_hold", 2'd1, 1'b1, 1'b1, 8'h3C);
      out_ready = 1'b1;  tick(); check_all("busy_out", 2'd0, 1'b0, 1'b1, 8'h3C);

      // Flush in FULL discards both held beats even with out_ready high.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h11; tick();
      in_data   = 8'h22; tick(); check_all("fl_full", 2'd2, 1'b1, 1'b0, 8'h11);
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'h33; tick(); check_all("fl_flush", 2'd0, 1'b0, 1'b1, RV);
      flush     = 1'b0;
      in_valid  = 1'b0;  tick(); check_all("fl_after", 2'd0, 1'b0, 1'b1, RV);

      // Flush while EMPTY discards a beat offered with in_ready high.
      flush     = 1'b1;
      in_valid  = 1'b1;
      in_data   = 8'h44; tick(); check_all("fl_empty", 2'd0, 1'b0, 1'b1, RV);
      flush     = 1'b0;
      in_valid  = 1'b0;

      // Flush in BUSY with both transfers offered: neither takes effect.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h4B; tick();
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'h4C; tick(); check_all("fl_busy", 2'd0, 1'b0, 1'b1, RV);
      flush     = 1'b0;
      in_valid  = 1'b0;

      // Reset beats flush and a pending transfer in FULL.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      in_data   = 8'h55; tick();
      in_data   = 8'h66; tick(); check_all("rp_full", 2'd2, 1'b1, 1'b0, 8'h55);
      reset     = 1'b1;
      flush     = 1'b1;
      out_ready = 1'b1;
      in_data   = 8'h99; tick(); check_all("rp_reset", 2'd0, 1'b0, 1'b1, RV);
      reset     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      tick();             check_all("rp_after", 2'd0, 1'b0, 1'b1, RV);

      // Random handshakes scored against a two-deep queue model.
      q.delete();
      for (int c = 0; c < 4000; c++) begin
         in_valid  = ($urandom_range(0, 3) != 0);
         out_ready = ($urandom_range(0, 2) != 0);
         in_data   = 8'($urandom);
         check("rnd.in_ready",  64'(in_ready),  64'(q.size() < 2));
         check("rnd.out_valid", 64'(out_valid), 64'(q.size() > 0));
         exp_in  = in_valid  && (q.size() < 2);
         exp_out = out_ready && (q.size() > 0);
         tick();
         if (exp_out) void'(q.pop_front());
         if (exp_in)  q.push_back(in_data);
         check("rnd.count", 64'(count), 64'(q.size()));
         if (q.size() > 0) check("rnd.out_data", 64'(out_data), 64'(q[0]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
